// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory-ack timeout, a sticky bus error, and cycle and retired-instruction counters.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              cur_state;
    state_t              next_state;
    logic [6:0]          op_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_inc;
    logic                timeout;
    logic                retire;
    logic                wait_done;

    assign state     = cur_state;
    assign halted    = (cur_state == S_HALT);
    assign wait_done = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next state and outputs; everything held at zero while reset is low
    always_comb begin
        next_state    = cur_state;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        wait_inc      = 1'b0;
        timeout       = 1'b0;
        if (reset) begin
            case (cur_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_write   = 1'b1;
                        next_state = S_DECODE;
                    end else if (wait_done) begin
                        timeout    = 1'b1;
                        next_state = S_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                S_DECODE: begin
                    next_state = S_EXEC;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LOAD, OP_STORE:  next_state = S_MEM;
                        OP_ALU, OP_ALUIMM:  next_state = S_WB;
                        OP_SYSTEM:          next_state = S_HALT;
                        default: begin
                            illegal_instr = 1'b1;
                            pc_write      = 1'b1;
                            next_state    = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_q == OP_STORE);
                    if (dmem_ack) begin
                        if (op_q == OP_STORE) begin
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            next_state = S_WB;
                        end
                    end else if (wait_done) begin
                        timeout    = 1'b1;
                        next_state = S_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
                S_HALT: begin
                    next_state = S_HALT;
                end
                default: begin
                    next_state = S_HALT;
                end
            endcase
        end
    end

    // Opcode captured at the end of DECODE so EXEC/MEM ignore later IR changes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
        end else if (cur_state == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Wait counter is zero whenever a request is not stalled, so every entry into FETCH/MEM starts at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_error <= 1'b0;
        end else if (timeout) begin
            bus_error <= 1'b1;
        end
    end

    // Both counters wrap silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (cur_state != S_HALT) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule
